seg_disp_ctrl: RTL and testbench

Controller that shares one binary-to-7-segment converter between two requesters and drives a 4-digit multiplexed display from its results. It arbitrates requests (round-robin), sequences the converter's convert/conv_done handshake with a timeout, and latches the 32-bit segment word. It then scans the word onto the display's segment and anode lines. It sits between the calculator core/keypad logic and the converter + board display.

---
 rtl/seg_disp_ctrl_if.sv | 31 +++
 rtl/seg_disp_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_disp_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_disp_ctrl_if.sv
// Bundles the requester, converter and display signals of seg_disp_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface seg_disp_ctrl_if;
    logic        req_a;
    logic [13:0] num_a;
    logic        err_a;
    logic        gnt_a;
    logic        req_b;
    logic [13:0] num_b;
    logic        err_b;
    logic        gnt_b;
    logic [13:0] conv_num;
    logic        conv_start;
    logic [31:0] conv_digits;
    logic        conv_done;
    logic        busy;
    logic        upd_done;
    logic        timeout;
    logic [7:0]  seg;
    logic [3:0]  an;

    modport slave (
        input  req_a, num_a, err_a, req_b, num_b, err_b, conv_digits, conv_done,
        output gnt_a, gnt_b, conv_num, conv_start, busy, upd_done, timeout, seg, an
    );

    modport master (
        output req_a, num_a, err_a, req_b, num_b, err_b, conv_digits, conv_done,
        input  gnt_a, gnt_b, conv_num, conv_start, busy, upd_done, timeout, seg, an
    );
endinterface

// File: rtl/seg_disp_ctrl.sv
// Round-robin front end for a shared binary-to-7-segment converter, plus a
// 4-digit multiplexed scanner that displays the most recently loaded word.
module seg_disp_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned TIMEOUT     = 32,
    parameter logic [31:0] ERR_PATTERN = 32'h763D507C
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_disp_ctrl_if.slave bus
);
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOAD} state_e;

    state_e             state_q, state_d;
    logic               last_b_q, last_b_d;
    logic [13:0]        num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        disp_q, disp_d;
    logic               timeout_q, timeout_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic               conv_start_q, conv_start_d;
    logic               busy_q, busy_d;
    logic               upd_done_q, upd_done_d;
    logic               pick_a;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;

    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.conv_num   = num_q;
    assign bus.conv_start = conv_start_q;
    assign bus.busy       = busy_q;
    assign bus.upd_done   = upd_done_q;
    assign bus.timeout    = timeout_q;
    assign bus.seg        = seg_q;
    assign bus.an         = an_q;

    // On a tie the requester that was not granted last wins.
    assign pick_a = bus.req_a && (!bus.req_b || last_b_q);

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        timeout_d  = timeout_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        upd_done_d = 1'b0;

        // The display word is written on the edge entering LOAD, so seg sees it one cycle after LOAD.
        case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    gnt_a_d  = pick_a;
                    gnt_b_d  = !pick_a;
                    last_b_d = !pick_a;
                    num_d    = pick_a ? bus.num_a : bus.num_b;
                    if (pick_a ? bus.err_a : bus.err_b) begin
                        disp_d     = ERR_PATTERN;
                        upd_done_d = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.conv_done) begin
                    disp_d     = bus.conv_digits;
                    timeout_d  = 1'b0;
                    upd_done_d = 1'b1;
                    state_d    = LOAD;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    disp_d     = ERR_PATTERN;
                    timeout_d  = 1'b1;
                    upd_done_d = 1'b1;
                    state_d    = LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        conv_start_d = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_b_q     <= 1'b1;
            num_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            timeout_q    <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            upd_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_b_q     <= last_b_d;
            num_q        <= num_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            timeout_q    <= timeout_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            upd_done_q   <= upd_done_d;
        end
    end

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_d);
        seg_d = disp_q[{idx_d, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1110;
            seg_q <= 8'h00;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl: arbitration, converter handshake, timeout,
// error bypass, async reset and scan order, with a small scan-phase model.
module tb_seg_disp_ctrl;
    localparam int unsigned REFRESH_DIV = 4;
    localparam int unsigned TIMEOUT     = 32;
    localparam logic [31:0] ERR_PATTERN = 32'h763D507C;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned edges;
    logic [31:0] expDisp;
    int          numChecks = 0;
    int          numFails  = 0;

    seg_disp_ctrl_if bus ();

    seg_disp_ctrl #(
        .REFRESH_DIV (REFRESH_DIV),
        .TIMEOUT     (TIMEOUT),
        .ERR_PATTERN (ERR_PATTERN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent count of clock edges since reset release gives the expected digit index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ra, input logic [13:0] na, input logic ea,
                                 input logic rb, input logic [13:0] nb, input logic eb);
        bus.req_a = ra;
        bus.num_a = na;
        bus.err_a = ea;
        bus.req_b = rb;
        bus.num_b = nb;
        bus.err_b = eb;
    endtask

    task automatic checkScan(input string tag, input logic [31:0] word);
        int unsigned idx;
        logic [3:0]  expAn;
        logic [7:0]  expSeg;
        idx    = (edges / REFRESH_DIV) % 4;
        expAn  = ~(4'b0001 << idx);
        expSeg = word[8*idx +: 8];
        checkOutput({tag, "_an"},  32'(bus.an),  32'(expAn));
        checkOutput({tag, "_seg"}, 32'(bus.seg), 32'(expSeg));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_gntA"},  32'(bus.gnt_a),      32'd0);
        checkOutput({tag, "_gntB"},  32'(bus.gnt_b),      32'd0);
        checkOutput({tag, "_start"}, 32'(bus.conv_start), 32'd0);
        checkOutput({tag, "_upd"},   32'(bus.upd_done),   32'd0);
        checkOutput({tag, "_busy"},  32'(bus.busy),       32'd0);
        checkOutput({tag, "_tmo"},   32'(bus.timeout),    32'd0);
        checkOutput({tag, "_num"},   32'(bus.conv_num),   32'd0);
        checkOutput({tag, "_an"},    32'(bus.an),         32'h0000000E);
        checkOutput({tag, "_seg"},   32'(bus.seg),        32'd0);
    endtask

    // Waits for a grant, then plays the converter returning digits 'latency' cycles after conv_start.
    task automatic doConversion(input string tag, input bit expectA, input bit dropReq,
                                input logic [13:0] num, input int latency, input logic [31:0] digits);
        int n;
        n = 0;
        tick();
        while (!(bus.gnt_a || bus.gnt_b) && n < 8) begin
            tick();
            n++;
        end
        checkOutput({tag, "_gntA"},  32'(bus.gnt_a),      32'(expectA));
        checkOutput({tag, "_gntB"},  32'(bus.gnt_b),      32'(!expectA));
        checkOutput({tag, "_start"}, 32'(bus.conv_start), 32'd1);
        checkOutput({tag, "_num"},   32'(bus.conv_num),   32'(num));
        if (dropReq) begin
            if (expectA) bus.req_a = 1'b0;
            else         bus.req_b = 1'b0;
        end
        tick();
        checkOutput({tag, "_startOff"}, 32'(bus.conv_start), 32'd0);
        checkOutput({tag, "_gntOff"},   32'({bus.gnt_a, bus.gnt_b}), 32'd0);
        for (int i = 1; i < latency; i++) tick();
        bus.conv_done   = 1'b1;
        bus.conv_digits = digits;
        tick();
        bus.conv_done   = 1'b0;
        bus.conv_digits = '0;
        checkOutput({tag, "_upd"},  32'(bus.upd_done), 32'd1);
        checkOutput({tag, "_tmo"},  32'(bus.timeout),  32'd0);
        checkScan({tag, "_old"}, expDisp);
        expDisp = digits;
        tick();
        checkOutput({tag, "_busyOff"}, 32'(bus.busy),     32'd0);
        checkOutput({tag, "_updOff"},  32'(bus.upd_done), 32'd0);
        checkScan({tag, "_new"}, expDisp);
    endtask

    // Called right after the edge that entered WAIT; optionally answers on the timeout cycle itself.
    task automatic runWait(input string tag, input bit coincident, input bit priorTimeout,
                           input logic [31:0] digits);
        for (int i = 0; i < int'(TIMEOUT); i++) tick();
        checkOutput({tag, "_updEarly"}, 32'(bus.upd_done), 32'd0);
        checkOutput({tag, "_busy"},     32'(bus.busy),     32'd1);
        checkOutput({tag, "_tmoPrior"}, 32'(bus.timeout),  32'(priorTimeout));
        if (coincident) begin
            bus.conv_done   = 1'b1;
            bus.conv_digits = digits;
        end
        tick();
        bus.conv_done   = 1'b0;
        bus.conv_digits = '0;
        checkOutput({tag, "_upd"}, 32'(bus.upd_done), 32'd1);
        checkOutput({tag, "_tmo"}, 32'(bus.timeout),  32'(!coincident));
        checkScan({tag, "_old"}, expDisp);
        expDisp = coincident ? digits : ERR_PATTERN;
        tick();
        checkOutput({tag, "_busyOff"}, 32'(bus.busy), 32'd0);
        checkScan({tag, "_new"}, expDisp);
    endtask

    task automatic startTimeoutRun(input string tag, input logic [13:0] num);
        applyStimulus(1'b1, num, 1'b0, 1'b0, 14'd0, 1'b0);
        tick();
        checkOutput({tag, "_gntA"},  32'(bus.gnt_a),      32'd1);
        checkOutput({tag, "_start"}, 32'(bus.conv_start), 32'd1);
        bus.req_a = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 1'b0);
        bus.conv_done   = 1'b0;
        bus.conv_digits = '0;
        expDisp = '0;
        tick();
        tick();
        checkResetState("init");
        rst_n = 1'b1;

        // Tie: both held, A wins first after reset, then strict alternation.
        applyStimulus(1'b1, 14'd11, 1'b0, 1'b1, 14'd22, 1'b0);
        doConversion("tie1", 1'b1, 1'b0, 14'd11, 2, 32'h0000063F);
        doConversion("tie2", 1'b0, 1'b0, 14'd22, 3, 32'h00005B5B);
        doConversion("tie3", 1'b1, 1'b0, 14'd11, 1, 32'h00000606);
        doConversion("tie4", 1'b0, 1'b1, 14'd22, 2, 32'h00005B5B);
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 1'b0);
        tick();

        // Reset mid-WAIT with req_a held, then the same request completes.
        applyStimulus(1'b1, 14'd1234, 1'b0, 1'b0, 14'd0, 1'b0);
        tick();
        checkOutput("rstPre_gntA", 32'(bus.gnt_a), 32'd1);
        tick();
        tick();
        checkOutput("rstPre_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetState("midWait");
        tick();
        rst_n = 1'b1;
        expDisp = '0;
        doConversion("single", 1'b1, 1'b1, 14'd1234, 5, 32'h664F5B06);

        for (int i = 0; i < 16; i++) begin
            tick();
            checkScan($sformatf("frame%0d", i), expDisp);
        end

        // Error bypass from B: no converter start, error word straight away.
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b1, 14'd5, 1'b1);
        tick();
        checkOutput("errB_gntB",  32'(bus.gnt_b),      32'd1);
        checkOutput("errB_start", 32'(bus.conv_start), 32'd0);
        checkOutput("errB_upd",   32'(bus.upd_done),   32'd1);
        checkOutput("errB_busy",  32'(bus.busy),       32'd1);
        checkScan("errB_old", expDisp);
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 1'b0);
        tick();
        expDisp = ERR_PATTERN;
        checkOutput("errB_busyOff", 32'(bus.busy),       32'd0);
        checkOutput("errB_tmo",     32'(bus.timeout),    32'd0);
        checkOutput("errB_noStart", 32'(bus.conv_start), 32'd0);
        checkScan("errB_new", expDisp);

        // Silent converter, then a good conversion clears the timeout flag.
        expDisp = 32'h00005B5B;
        startTimeoutRun("tmo1", 14'd7);
        expDisp = ERR_PATTERN;
        runWait("tmo1", 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b1, 14'd42, 1'b0);
        doConversion("clear", 1'b0, 1'b1, 14'd42, 2, 32'h3F3F3F3F);

        // Timeout again, then conv_done lands exactly on the timeout cycle.
        startTimeoutRun("tmo2", 14'd9);
        runWait("tmo2", 1'b0, 1'b0, 32'h0);
        startTimeoutRun("coin", 14'd8);
        runWait("coin", 1'b1, 1'b1, 32'h7F6F7F6F);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion before 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
